// File: rtl/ddr_data_port.sv
// ddr_data_port: bridge between data_cache and the DDR burst controller.
//
// Accepts one block refill (read) or block write-back (write) request at a time from
// data_cache. Each request becomes a single fixed-length burst to the controller.
// Write-back has priority over refill when both are pending in IDLE.
//
// Ports
//   clk, rst                       system clock, asynchronous active-low reset
//   DATA_read_req/_addr            refill request (level) and start address
//   DATA_store_req/DATA_write_addr write-back request (level) and start address
//   DATA_to_ddr                    write data from data_cache, one cycle after pull strobe
//   DATA_to_cache                  read beat to data_cache
//   rd_cnt_data                    read beat counter (beat k is presented with count k+2)
//   rd_burst_data_valid            DATA_to_cache valid
//   wr_burst_data_req              pull strobe to data_cache
//   state_interface_module         current state encoding
//   ddr_rd_burst_*                 read burst request/address/length/data/valid/finish
//   ddr_wr_burst_*                 write burst request/address/length/data/pull/finish
module ddr_data_port #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned DDR_ADDR_WIDTH = 28,
    parameter int unsigned BURST_LEN      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    // data_cache side
    input  logic                      DATA_read_req,
    input  logic                      DATA_store_req,
    input  logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr,
    input  logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr,
    input  logic [DATA_WIDTH-1:0]     DATA_to_ddr,
    output logic [DATA_WIDTH-1:0]     DATA_to_cache,
    output logic [9:0]                rd_cnt_data,
    output logic                      rd_burst_data_valid,
    output logic                      wr_burst_data_req,
    output logic [3:0]                state_interface_module,
    // controller read channel
    output logic                      ddr_rd_burst_req,
    output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_burst_addr,
    output logic [9:0]                ddr_rd_burst_len,
    input  logic [DATA_WIDTH-1:0]     ddr_rd_burst_data,
    input  logic                      ddr_rd_burst_data_valid,
    input  logic                      ddr_rd_burst_finish,
    // controller write channel
    output logic                      ddr_wr_burst_req,
    output logic [DDR_ADDR_WIDTH-1:0] ddr_wr_burst_addr,
    output logic [9:0]                ddr_wr_burst_len,
    output logic [DATA_WIDTH-1:0]     ddr_wr_burst_data,
    input  logic                      ddr_wr_burst_data_req,
    input  logic                      ddr_wr_burst_finish
);

    typedef enum logic [3:0] {
        StIdle              = 4'd1,
        StMemReadData       = 4'd8,
        StMemWriteDataStore = 4'd9,
        StDone              = 4'd10
    } state_t;

    state_t state;

    assign state_interface_module = state;
    assign ddr_rd_burst_len       = 10'(BURST_LEN);
    assign ddr_wr_burst_len       = 10'(BURST_LEN);

    // The controller wants write data one cycle after its strobe, and data_cache supplies
    // data one cycle after its strobe, so both paths are plain combinational forwards.
    assign wr_burst_data_req = (state == StMemWriteDataStore) && ddr_wr_burst_data_req;
    assign ddr_wr_burst_data = (state == StMemWriteDataStore) ? DATA_to_ddr : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= StIdle;
            DATA_to_cache       <= '0;
            rd_cnt_data         <= '0;
            rd_burst_data_valid <= 1'b0;
            ddr_rd_burst_req    <= 1'b0;
            ddr_rd_burst_addr   <= '0;
            ddr_wr_burst_req    <= 1'b0;
            ddr_wr_burst_addr   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    rd_burst_data_valid <= 1'b0;
                    if (DATA_store_req) begin
                        ddr_wr_burst_addr <= DATA_write_addr;
                        ddr_wr_burst_req  <= 1'b1;
                        state             <= StMemWriteDataStore;
                    end else if (DATA_read_req) begin
                        ddr_rd_burst_addr <= DATA_read_addr;
                        ddr_rd_burst_req  <= 1'b1;
                        rd_cnt_data       <= 10'd1;
                        state             <= StMemReadData;
                    end
                end

                StMemReadData: begin
                    rd_burst_data_valid <= ddr_rd_burst_data_valid;
                    if (ddr_rd_burst_data_valid) begin
                        ddr_rd_burst_req <= 1'b0;
                        DATA_to_cache    <= ddr_rd_burst_data;
                        // Saturate so overlong bursts cannot wrap the count back to 0.
                        if (rd_cnt_data != 10'h3FF) begin
                            rd_cnt_data <= rd_cnt_data + 10'd1;
                        end
                    end
                    if (ddr_rd_burst_finish) begin
                        ddr_rd_burst_req <= 1'b0;
                        state            <= StDone;
                    end
                end

                StMemWriteDataStore: begin
                    rd_burst_data_valid <= 1'b0;
                    if (ddr_wr_burst_data_req || ddr_wr_burst_finish) begin
                        ddr_wr_burst_req <= 1'b0;
                    end
                    if (ddr_wr_burst_finish) begin
                        state <= StDone;
                    end
                end

                StDone: begin
                    rd_burst_data_valid <= 1'b0;
                    // Hold here until data_cache releases both requests so a request that
                    // is still high from the finished burst does not start another one.
                    if (!DATA_read_req && !DATA_store_req) begin
                        rd_cnt_data <= '0;
                        state       <= StIdle;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_data_port.sv
// Self-checking bench for ddr_data_port. Directed stimulus; read beats and write beats
// are checked by monitors popping expected values from scoreboard queues.
module tb_ddr_data_port;

    localparam int DW    = 16;
    localparam int AW    = 28;
    localparam int BURST = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          DATA_read_req = 1'b0;
    logic          DATA_store_req = 1'b0;
    logic [AW-1:0] DATA_read_addr = '0;
    logic [AW-1:0] DATA_write_addr = '0;
    logic [DW-1:0] DATA_to_ddr = '0;
    logic [DW-1:0] DATA_to_cache;
    logic [9:0]    rd_cnt_data;
    logic          rd_burst_data_valid;
    logic          wr_burst_data_req;
    logic [3:0]    state_interface_module;
    logic          ddr_rd_burst_req;
    logic [AW-1:0] ddr_rd_burst_addr;
    logic [9:0]    ddr_rd_burst_len;
    logic [DW-1:0] ddr_rd_burst_data = '0;
    logic          ddr_rd_burst_data_valid = 1'b0;
    logic          ddr_rd_burst_finish = 1'b0;
    logic          ddr_wr_burst_req;
    logic [AW-1:0] ddr_wr_burst_addr;
    logic [9:0]    ddr_wr_burst_len;
    logic [DW-1:0] ddr_wr_burst_data;
    logic          ddr_wr_burst_data_req = 1'b0;
    logic          ddr_wr_burst_finish = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [25:0] exp_rd[$];  // {data, rd_cnt_data}
    logic [15:0] exp_wr[$];
    int          wexp = 0;   // expected write word index
    int          wmod = 0;   // data_cache model word index
    bit          wr_active = 1'b0;
    logic        strobe_q = 1'b0;

    ddr_data_port #(
        .DATA_WIDTH    (DW),
        .DDR_ADDR_WIDTH(AW),
        .BURST_LEN     (BURST)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .DATA_read_req          (DATA_read_req),
        .DATA_store_req         (DATA_store_req),
        .DATA_read_addr         (DATA_read_addr),
        .DATA_write_addr        (DATA_write_addr),
        .DATA_to_ddr            (DATA_to_ddr),
        .DATA_to_cache          (DATA_to_cache),
        .rd_cnt_data            (rd_cnt_data),
        .rd_burst_data_valid    (rd_burst_data_valid),
        .wr_burst_data_req      (wr_burst_data_req),
        .state_interface_module (state_interface_module),
        .ddr_rd_burst_req       (ddr_rd_burst_req),
        .ddr_rd_burst_addr      (ddr_rd_burst_addr),
        .ddr_rd_burst_len       (ddr_rd_burst_len),
        .ddr_rd_burst_data      (ddr_rd_burst_data),
        .ddr_rd_burst_data_valid(ddr_rd_burst_data_valid),
        .ddr_rd_burst_finish    (ddr_rd_burst_finish),
        .ddr_wr_burst_req       (ddr_wr_burst_req),
        .ddr_wr_burst_addr      (ddr_wr_burst_addr),
        .ddr_wr_burst_len       (ddr_wr_burst_len),
        .ddr_wr_burst_data      (ddr_wr_burst_data),
        .ddr_wr_burst_data_req  (ddr_wr_burst_data_req),
        .ddr_wr_burst_finish    (ddr_wr_burst_finish)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // data_cache model: supplies the next write word one cycle after each pull strobe.
    always @(posedge clk) begin
        if (wr_burst_data_req) begin
            DATA_to_ddr <= 16'hB000 + 16'(wmod);
            wmod        <= wmod + 1;
        end
    end

    always @(posedge clk) strobe_q <= ddr_wr_burst_data_req && wr_active;

    // Read monitor.
    always @(negedge clk) begin
        if (rst && rd_burst_data_valid) begin
            if (exp_rd.size() == 0) begin
                chk("rd_unexpected_valid", 32'd1, 32'd0);
            end else begin
                logic [25:0] e;
                e = exp_rd.pop_front();
                chk("rd_data", 32'(DATA_to_cache), 32'(e[25:10]));
                chk("rd_cnt", 32'(rd_cnt_data), 32'(e[9:0]));
            end
        end
    end

    // Write monitor: data must be on the controller bus one cycle after its strobe.
    always @(negedge clk) begin
        if (rst && strobe_q) begin
            if (exp_wr.size() == 0) begin
                chk("wr_unexpected", 32'd1, 32'd0);
            end else begin
                logic [15:0] e;
                e = exp_wr.pop_front();
                chk("wr_data", 32'(ddr_wr_burst_data), 32'(e));
            end
        end
    end

    task automatic rd_grant(input logic [AW-1:0] addr);
        DATA_read_addr = addr;
        DATA_read_req  = 1'b1;
        step();
        chk("rd_grant_state", 32'(state_interface_module), 32'd8);
        chk("rd_grant_req", 32'(ddr_rd_burst_req), 32'd1);
        chk("rd_grant_addr", 32'(ddr_rd_burst_addr), 32'(addr));
        chk("rd_grant_len", 32'(ddr_rd_burst_len), 32'd16);
        chk("rd_grant_cnt", 32'(rd_cnt_data), 32'd1);
    endtask

    // Controller returns BURST beats (optionally with 2-cycle gaps), then finish.
    task automatic rd_beats(input logic [15:0] base, input bit gaps);
        int n = 0;
        int c = 0;
        while (n < BURST) begin
            if (!gaps || (c % 4) < 2) begin
                ddr_rd_burst_data_valid = 1'b1;
                ddr_rd_burst_data       = base + 16'(n);
                exp_rd.push_back({base + 16'(n), 10'(n + 2)});
                n++;
            end else begin
                ddr_rd_burst_data_valid = 1'b0;
                ddr_rd_burst_data       = 16'hDEAD;
            end
            c++;
            step();
            if (c == 1) chk("rd_req_drop", 32'(ddr_rd_burst_req), 32'd0);
            if (gaps && c == 4) chk("rd_gap_cnt", 32'(rd_cnt_data), 32'd3);
        end
        ddr_rd_burst_data_valid = 1'b0;
        ddr_rd_burst_finish     = 1'b1;
        step();
        ddr_rd_burst_finish = 1'b0;
        chk("rd_done_state", 32'(state_interface_module), 32'd10);
        chk("rd_done_cnt", 32'(rd_cnt_data), 32'd17);
        step();
        chk("rd_done_hold_state", 32'(state_interface_module), 32'd10);
        chk("rd_done_hold_cnt", 32'(rd_cnt_data), 32'd17);
        DATA_read_req = 1'b0;
        step();
        chk("rd_idle_state", 32'(state_interface_module), 32'd1);
        chk("rd_idle_cnt", 32'(rd_cnt_data), 32'd0);
        chk("rd_sb_empty", 32'(exp_rd.size()), 32'd0);
    endtask

    // Controller strobes BURST times with one idle cycle in the middle, then finish.
    task automatic wr_beats();
        int n = 0;
        int c = 0;
        wr_active = 1'b1;
        while (n < BURST) begin
            if (c == 8) begin
                ddr_wr_burst_data_req = 1'b0;
                #1 chk("wr_pull_gap", 32'(wr_burst_data_req), 32'd0);
            end else begin
                ddr_wr_burst_data_req = 1'b1;
                exp_wr.push_back(16'hB000 + 16'(wexp));
                wexp++;
                n++;
                #1 chk("wr_pull_mirror", 32'(wr_burst_data_req), 32'd1);
            end
            c++;
            step();
            if (c == 1) chk("wr_req_drop", 32'(ddr_wr_burst_req), 32'd0);
        end
        ddr_wr_burst_data_req = 1'b0;
        ddr_wr_burst_finish   = 1'b1;
        step();
        ddr_wr_burst_finish = 1'b0;
        wr_active           = 1'b0;
        chk("wr_done_state", 32'(state_interface_module), 32'd10);
        chk("wr_sb_empty", 32'(exp_wr.size()), 32'd0);
    endtask

    task automatic wr_check_grant(input logic [AW-1:0] addr);
        chk("wr_grant_state", 32'(state_interface_module), 32'd9);
        chk("wr_grant_req", 32'(ddr_wr_burst_req), 32'd1);
        chk("wr_grant_addr", 32'(ddr_wr_burst_addr), 32'(addr));
        chk("wr_grant_len", 32'(ddr_wr_burst_len), 32'd16);
        chk("wr_grant_no_rd", 32'(ddr_rd_burst_req), 32'd0);
    endtask

    initial begin
        // Reset state.
        #12;
        chk("rst_state", 32'(state_interface_module), 32'd1);
        chk("rst_cnt", 32'(rd_cnt_data), 32'd0);
        chk("rst_rd_req", 32'(ddr_rd_burst_req), 32'd0);
        chk("rst_wr_req", 32'(ddr_wr_burst_req), 32'd0);
        chk("rst_valid", 32'(rd_burst_data_valid), 32'd0);
        chk("rst_to_cache", 32'(DATA_to_cache), 32'd0);
        chk("rst_wr_data", 32'(ddr_wr_burst_data), 32'd0);
        chk("rst_len", 32'(ddr_rd_burst_len), 32'd16);
        step();
        rst = 1'b1;
        step();

        // Plain read burst.
        rd_grant(28'h0028000);
        rd_beats(16'hA000, 1'b0);

        // Plain write burst.
        DATA_write_addr = 28'h0028080;
        DATA_store_req  = 1'b1;
        step();
        wr_check_grant(28'h0028080);
        wr_beats();
        DATA_store_req = 1'b0;
        step();
        chk("wr_idle_state", 32'(state_interface_module), 32'd1);

        // Simultaneous requests: write first, read only after DONE with both low.
        DATA_write_addr = 28'h0030100;
        DATA_read_addr  = 28'h0030000;
        DATA_store_req  = 1'b1;
        DATA_read_req   = 1'b1;
        step();
        wr_check_grant(28'h0030100);
        wr_beats();
        DATA_store_req = 1'b0;
        step();
        chk("prio_done_hold", 32'(state_interface_module), 32'd10);
        chk("prio_no_rd_req", 32'(ddr_rd_burst_req), 32'd0);
        DATA_read_req = 1'b0;
        step();
        chk("prio_idle", 32'(state_interface_module), 32'd1);
        rd_grant(28'h0030000);
        rd_beats(16'hC000, 1'b0);

        // Read with gaps in the valid stream.
        rd_grant(28'h0040000);
        rd_beats(16'h5000, 1'b1);

        // Reset during beat 7 of a read.
        rd_grant(28'h0050000);
        for (int i = 0; i < 7; i++) begin
            ddr_rd_burst_data_valid = 1'b1;
            ddr_rd_burst_data       = 16'h7000 + 16'(i);
            exp_rd.push_back({16'h7000 + 16'(i), 10'(i + 2)});
            step();
        end
        ddr_rd_burst_data_valid = 1'b1;
        ddr_rd_burst_data       = 16'h7007;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("arst_state", 32'(state_interface_module), 32'd1);
        chk("arst_cnt", 32'(rd_cnt_data), 32'd0);
        chk("arst_valid", 32'(rd_burst_data_valid), 32'd0);
        chk("arst_rd_req", 32'(ddr_rd_burst_req), 32'd0);
        chk("arst_rd_addr", 32'(ddr_rd_burst_addr), 32'd0);
        chk("arst_to_cache", 32'(DATA_to_cache), 32'd0);
        chk("arst_sb_empty", 32'(exp_rd.size()), 32'd0);
        ddr_rd_burst_data_valid = 1'b0;
        DATA_read_req           = 1'b0;
        step();
        rst = 1'b1;
        step();
        rd_grant(28'h0050000);
        rd_beats(16'h7100, 1'b0);

        // Stray finish pulses and strobe in IDLE.
        ddr_wr_burst_finish   = 1'b1;
        ddr_rd_burst_finish   = 1'b1;
        ddr_wr_burst_data_req = 1'b1;
        #1 chk("stray_pull", 32'(wr_burst_data_req), 32'd0);
        step();
        ddr_wr_burst_finish   = 1'b0;
        ddr_rd_burst_finish   = 1'b0;
        ddr_wr_burst_data_req = 1'b0;
        chk("stray_state", 32'(state_interface_module), 32'd1);
        chk("stray_wr_req", 32'(ddr_wr_burst_req), 32'd0);
        chk("stray_rd_req", 32'(ddr_rd_burst_req), 32'd0);
        step();
        chk("stray_valid", 32'(rd_burst_data_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ddr_data_port.md
Name: ddr_data_port

Overview:
- Sits between data_cache and the DDR burst controller.
- Accepts data_cache block read (refill) and block write (write-back) requests.
- Issues one fixed-length burst per request to the controller.
- Returns the beat counter, valid and write-pull strobes, and interface state that data_cache consumes.

Parameters:
DATA_WIDTH, 16, DDR beat width (equals cache word width)
DDR_ADDR_WIDTH, 28, DDR byte/beat address width
BURST_LEN, 16, beats per burst (equals DATA_CACHE_DEPTH)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
DATA_read_req  input  1  refill request from data_cache, level, held until served
DATA_store_req  input  1  write-back request from data_cache, level
DATA_read_addr  input  DDR_ADDR_WIDTH  refill start address
DATA_write_addr  input  DDR_ADDR_WIDTH  write-back start address
DATA_to_ddr  input  DATA_WIDTH  write data from data_cache, valid 1 cycle after wr_burst_data_req
DATA_to_cache  output  DATA_WIDTH  read beat to data_cache
rd_cnt_data  output  10  read beat counter
rd_burst_data_valid  output  1  DATA_to_cache valid
wr_burst_data_req  output  1  pull strobe to data_cache
state_interface_module  output  4  current state encoding
ddr_rd_burst_req  output  1  read burst request to controller
ddr_rd_burst_addr  output  DDR_ADDR_WIDTH  read start address
ddr_rd_burst_len  output  10  read length (BURST_LEN)
ddr_rd_burst_data  input  DATA_WIDTH  read beat from controller
ddr_rd_burst_data_valid  input  1  read beat valid
ddr_rd_burst_finish  input  1  read burst done pulse
ddr_wr_burst_req  output  1  write burst request
ddr_wr_burst_addr  output  DDR_ADDR_WIDTH  write start address
ddr_wr_burst_len  output  10  write length (BURST_LEN)
ddr_wr_burst_data  output  DATA_WIDTH  write beat
ddr_wr_burst_data_req  input  1  controller pull strobe, expects data next cycle
ddr_wr_burst_finish  input  1  write burst done pulse

Behaviour:
- States and encodings on state_interface_module:
  - IDLE=4'd1
  - MEM_READ_DATA=4'd8
  - MEM_WRITE_DATA_STORE=4'd9
  - DONE=4'd10
- Reset, asynchronous: state IDLE, all req/valid/strobe outputs 0, addresses 0, rd_cnt_data 0, DATA_to_cache 0, ddr_wr_burst_data 0. Len outputs are the constant BURST_LEN.
- Reset asserted mid-burst abandons the burst immediately; no completion is reported.
- IDLE:
  - DATA_store_req=1 has priority over DATA_read_req (write-back before refill).
  - On grant, the matching address is latched into ddr_*_burst_addr and the matching ddr_*_burst_req is set the next cycle.
  - Read grant sets rd_cnt_data<=1.
- ddr_*_burst_req stays high until the first ddr_rd_burst_data_valid (read) or first ddr_wr_burst_data_req (write), then drops.
- MEM_READ_DATA, per cycle with ddr_rd_burst_data_valid=1:
  - DATA_to_cache<=ddr_rd_burst_data
  - rd_burst_data_valid<=1
  - rd_cnt_data<=rd_cnt_data+1
  - Registered outputs: beat k (0-based) appears with rd_cnt_data=k+2 in the same cycle as valid.
  - rd_burst_data_valid is 0 in cycles without an input beat.
- ddr_rd_burst_finish moves MEM_READ_DATA to DONE. rd_cnt_data then holds at BURST_LEN+1 (17) until DONE exits.
- MEM_WRITE_DATA_STORE:
  - wr_burst_data_req = ddr_wr_burst_data_req, combinational, gated by state.
  - ddr_wr_burst_data = DATA_to_ddr, combinational pass-through.
  - Net latency: controller strobe to data is 1 cycle, matching controller expectation.
- ddr_wr_burst_finish moves MEM_WRITE_DATA_STORE to DONE.
- DONE: wait until both DATA_read_req and DATA_store_req are 0, then go to IDLE and clear rd_cnt_data to 0. This prevents retriggering on a still-held request.
- finish pulse outside its matching state is ignored. Extra valid beats beyond BURST_LEN still forward, and the counter saturates at 1023.
- Requests are not queued; a request arriving during a burst waits in IDLE arbitration.

Test Plan:
- Read 0x28000, controller returns 16 beats 0xA000..0xA00F -> ddr_rd_burst_req one cycle after grant, ddr_rd_burst_addr=0x28000, len=16; valid pulses carry rd_cnt_data 2..17 with matching data; counter holds 17 until req drops, then 0.
- Write 0x28080 with controller strobing 16 times -> wr_burst_data_req mirrors strobes only in state 9; ddr_wr_burst_data equals DATA_to_ddr each cycle; DONE on finish.
- DATA_read_req and DATA_store_req rise the same cycle -> write burst served first; read burst follows only after DONE and both requests low, then read reasserted.
- Read with valid gaps (beats on cycles 0,1,4,5,...) -> rd_burst_data_valid 0 in gap cycles, counter does not advance, final count 17.
- rst low during beat 7 of a read -> all outputs 0, state IDLE (state_interface_module=1) asynchronously; a new read after release restarts at rd_cnt_data=1.
- Stray ddr_wr_burst_finish in IDLE -> no state change, no outputs.
